// File: rtl/vc_input_unit.sv
// vc_input_unit: NoC router input port with VC_NUM virtual channels.
// Each VC has a first-word-fall-through flit FIFO and an IDLE/WAITING/ACTIVE
// packet FSM. WAITING VCs present their header to the allocator. ACTIVE VCs
// compete in a round-robin arbiter for the single registered output stage.
module vc_input_unit #(
  parameter int VC_NUM     = 4,
  parameter int VC_DEPTH_W = 2,
  parameter int DATA_W     = 10,
  parameter int ID_W       = 2,
  parameter int HEADER_ID  = 1,
  parameter int BODY_ID    = 2,
  parameter int TAIL_ID    = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [$clog2(VC_NUM)-1:0]  vc_sel_i,
  input  logic                       wr_en_i,
  output logic [VC_NUM-1:0]          rdy_o,
  output logic [VC_NUM-1:0]          req_o,
  output logic [VC_NUM*DATA_W-1:0]   header_o,
  input  logic [VC_NUM-1:0]          alloc_gnt_i,
  input  logic [VC_NUM-1:0]          chan_rdy_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       data_vld_o,
  output logic [$clog2(VC_NUM)-1:0]  vc_o,
  output logic [VC_NUM-1:0]          err_o
);

  localparam int VC_W  = $clog2(VC_NUM);
  localparam int DEPTH = 1 << VC_DEPTH_W;
  localparam logic [ID_W-1:0]     HDR      = ID_W'(HEADER_ID);
  localparam logic [ID_W-1:0]     BDY      = ID_W'(BODY_ID);
  localparam logic [ID_W-1:0]     TAL      = ID_W'(TAIL_ID);
  localparam logic [VC_DEPTH_W:0] CNT_FULL = (VC_DEPTH_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_ACTIVE  = 2'd2
  } vc_state_e;

  function automatic logic [ID_W-1:0] flit_id(input logic [DATA_W-1:0] f);
    return f[DATA_W-1 -: ID_W];
  endfunction

  function automatic logic id_known(input logic [ID_W-1:0] id);
    return (id == HDR) || (id == BDY) || (id == TAL);
  endfunction

  logic [DATA_W-1:0]     mem_q    [VC_NUM][DEPTH];
  logic [VC_DEPTH_W-1:0] wr_ptr_q [VC_NUM];
  logic [VC_DEPTH_W-1:0] rd_ptr_q [VC_NUM];
  logic [VC_DEPTH_W:0]   cnt_q    [VC_NUM];
  vc_state_e             state_q  [VC_NUM];
  vc_state_e             state_d  [VC_NUM];
  logic [VC_NUM-1:0]     first_q, first_d;
  logic [VC_NUM-1:0]     err_q, err_d;
  logic [VC_W-1:0]       ptr_q, ptr_d;
  logic [DATA_W-1:0]     data_q;
  logic [VC_W-1:0]       vc_q;
  logic                  vld_q;

  logic [DATA_W-1:0]     head_s [VC_NUM];
  logic [VC_NUM-1:0]     empty_s, full_s, push_s, drop_s, elig_s, pop_s;
  logic                  gnt_vld_s;
  logic [VC_W-1:0]       gnt_idx_s;

  // Per-VC head flit, occupancy flags, write acceptance and arbiter eligibility.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      head_s[v]  = mem_q[v][rd_ptr_q[v]];
      empty_s[v] = (cnt_q[v] == '0);
      full_s[v]  = (cnt_q[v] == CNT_FULL);
      push_s[v]  = wr_en_i && (vc_sel_i == VC_W'(v)) && !full_s[v];
      drop_s[v]  = wr_en_i && (vc_sel_i == VC_W'(v)) && full_s[v];
      elig_s[v]  = (state_q[v] == ST_ACTIVE) && !empty_s[v] && chan_rdy_i[v];
    end
  end

  // Round-robin pick: scan from lowest to highest priority so the VC nearest
  // the pointer is written last and wins.
  always_comb begin
    logic [VC_W:0] idx_v;
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      idx_v = {1'b0, ptr_q} + (VC_W+1)'(i);
      idx_v = (idx_v >= (VC_W+1)'(VC_NUM)) ? idx_v - (VC_W+1)'(VC_NUM) : idx_v;
      gnt_idx_s = elig_s[idx_v[VC_W-1:0]] ? idx_v[VC_W-1:0] : gnt_idx_s;
      gnt_vld_s = gnt_vld_s | elig_s[idx_v[VC_W-1:0]];
    end
    ptr_d = gnt_vld_s ? ((gnt_idx_s == VC_W'(VC_NUM - 1)) ? '0 : gnt_idx_s + 1'b1)
                      : ptr_q;
  end

  // Packet FSM next state, pop decision and error detection for every VC.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      state_d[v] = state_q[v];
      first_d[v] = first_q[v];
      err_d[v]   = drop_s[v];
      pop_s[v]   = 1'b0;
      case (state_q[v])
        ST_IDLE: begin
          if (!empty_s[v] && (flit_id(head_s[v]) == HDR)) begin
            state_d[v] = ST_WAITING;
          end else if (!empty_s[v]) begin
            // Stray non-header flit outside a packet: drop it.
            pop_s[v] = 1'b1;
            err_d[v] = 1'b1;
          end else begin
            state_d[v] = ST_IDLE;
          end
        end
        ST_WAITING: begin
          if (alloc_gnt_i[v]) begin
            state_d[v] = ST_ACTIVE;
            first_d[v] = 1'b1;
          end else begin
            state_d[v] = ST_WAITING;
          end
        end
        ST_ACTIVE: begin
          if (gnt_vld_s && (gnt_idx_s == VC_W'(v))) begin
            pop_s[v]   = 1'b1;
            first_d[v] = 1'b0;
            state_d[v] = (flit_id(head_s[v]) == TAL) ? ST_IDLE : ST_ACTIVE;
            err_d[v]   = drop_s[v]
                       | ((flit_id(head_s[v]) == HDR) && !first_q[v])
                       | !id_known(flit_id(head_s[v]));
          end else begin
            state_d[v] = ST_ACTIVE;
          end
        end
        default: begin
          state_d[v] = ST_IDLE;
        end
      endcase
    end
  end

  // Flit storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (push_s[v]) begin
        mem_q[v][wr_ptr_q[v]] <= data_i;
      end
    end
  end

  // FIFO pointers, occupancy counters and FSM state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        state_q[v]  <= ST_IDLE;
      end
      first_q <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= push_s[v] ? wr_ptr_q[v] + 1'b1 : wr_ptr_q[v];
        rd_ptr_q[v] <= pop_s[v]  ? rd_ptr_q[v] + 1'b1 : rd_ptr_q[v];
        case ({push_s[v], pop_s[v]})
          2'b10:   cnt_q[v] <= cnt_q[v] + 1'b1;
          2'b01:   cnt_q[v] <= cnt_q[v] - 1'b1;
          default: cnt_q[v] <= cnt_q[v];
        endcase
        state_q[v] <= state_d[v];
      end
      first_q <= first_d;
    end
  end

  // Arbiter pointer, error pulses and the forwarding output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
      vc_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      if (gnt_vld_s) begin
        data_q <= head_s[gnt_idx_s];
        vc_q   <= gnt_idx_s;
        vld_q  <= 1'b1;
      end else begin
        vld_q  <= 1'b0;
      end
    end
  end

  // Status outputs: backpressure, allocation requests and header presentation.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      rdy_o[v] = !full_s[v];
      req_o[v] = (state_q[v] == ST_WAITING);
      header_o[v*DATA_W +: DATA_W] = (state_q[v] == ST_WAITING) ? head_s[v] : '0;
    end
  end

  assign data_o     = data_q;
  assign data_vld_o = vld_q;
  assign vc_o       = vc_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// tb_vc_input_unit: directed scenarios plus random traffic, checked every
// cycle against a queue-based packet-level reference model.
module tb_vc_input_unit;

  localparam int VCN = 4;
  localparam int DW  = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   data;
  logic [1:0]      vc_sel;
  logic            wr_en;
  logic [VCN-1:0]  rdy, req, alloc_gnt, chan_rdy, err;
  logic [VCN*DW-1:0] header;
  logic [DW-1:0]   dout;
  logic            dvld;
  logic [1:0]      vc_out;

  vc_input_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .vc_sel_i(vc_sel),
    .wr_en_i(wr_en), .rdy_o(rdy), .req_o(req), .header_o(header),
    .alloc_gnt_i(alloc_gnt), .chan_rdy_i(chan_rdy), .data_o(dout),
    .data_vld_o(dvld), .vc_o(vc_out), .err_o(err)
  );

  always #5 clk = ~clk;

  // Reference model: one flit queue and one packet phase per VC
  // (0 = no packet, 1 = header awaiting allocation, 2 = forwarding).
  logic [DW-1:0] mq [0:VCN-1][$];
  int            mphase [VCN];
  bit            mfirst [VCN];
  int            mptr;
  logic [DW-1:0] m_data;
  int            m_vc;
  bit            m_vld;
  logic [VCN-1:0] m_err;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] seen [$];
  int gpos [VCN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int t, input int p);
    logic [1:0] tt;
    logic [7:0] pp;
    tt = t[1:0];
    pp = p[7:0];
    return {tt, pp};
  endfunction

  function automatic int ftype(input logic [DW-1:0] f);
    return int'(f[DW-1 -: 2]);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VCN; v++) begin
      mq[v].delete();
      mphase[v] = 0;
      mfirst[v] = 1'b0;
      gpos[v]   = 0;
    end
    mptr = 0; m_data = '0; m_vc = 0; m_vld = 1'b0; m_err = '0;
  endtask

  task automatic model_step(input bit w, input int s, input logic [DW-1:0] d,
                            input logic [VCN-1:0] g, input logic [VCN-1:0] c);
    bit full_w;
    int win;
    int t;
    logic [DW-1:0] wf;
    full_w = (mq[s].size() >= 4);
    win = -1;
    wf = '0;
    for (int i = 0; i < VCN; i++) begin
      int v;
      v = (mptr + i) % VCN;
      if (win < 0 && mphase[v] == 2 && mq[v].size() > 0 && c[v]) win = v;
    end
    m_err = '0;
    for (int v = 0; v < VCN; v++) begin
      if (mphase[v] == 0) begin
        if (mq[v].size() > 0) begin
          if (ftype(mq[v][0]) == 1) mphase[v] = 1;
          else begin
            void'(mq[v].pop_front());
            m_err[v] = 1'b1;
          end
        end
      end else if (mphase[v] == 1) begin
        if (g[v]) begin
          mphase[v] = 2;
          mfirst[v] = 1'b1;
        end
      end else if (v == win) begin
        wf = mq[v].pop_front();
        t = ftype(wf);
        if (t == 3) mphase[v] = 0;
        if ((t == 1 && !mfirst[v]) || t == 0) m_err[v] = 1'b1;
        mfirst[v] = 1'b0;
      end
    end
    if (win >= 0) begin
      m_data = wf; m_vc = win; m_vld = 1'b1; mptr = (win + 1) % VCN;
    end else begin
      m_vld = 1'b0;
    end
    if (w) begin
      if (full_w) m_err[s] = 1'b1;
      else mq[s].push_back(d);
    end
  endtask

  task automatic compare();
    logic [VCN-1:0]    e_rdy, e_req;
    logic [VCN*DW-1:0] e_hdr;
    for (int v = 0; v < VCN; v++) begin
      e_rdy[v] = (mq[v].size() < 4);
      e_req[v] = (mphase[v] == 1);
      e_hdr[v*DW +: DW] = (mphase[v] == 1) ? mq[v][0] : '0;
    end
    check("rdy_o", rdy, e_rdy);
    check("req_o", req, e_req);
    check("header_o", header, e_hdr);
    check("data_vld_o", dvld, m_vld);
    check("data_o", dout, m_data);
    check("vc_o", vc_out, m_vc);
    check("err_o", err, m_err);
    if (dvld) seen.push_back(dout);
  endtask

  task automatic cycle(input bit w, input int s, input logic [DW-1:0] d,
                       input logic [VCN-1:0] g, input logic [VCN-1:0] c);
    @(negedge clk);
    compare();
    wr_en = w; vc_sel = s[1:0]; data = d; alloc_gnt = g; chan_rdy = c;
    model_step(w, s, d, g, c);
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic [VCN-1:0] g);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, g, 4'hF);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0; alloc_gnt = '0; chan_rdy = '0; data = '0; vc_sel = '0;
    model_reset();
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] gen_flit(input int v);
    int t;
    if ($urandom_range(0, 15) == 0) t = $urandom_range(0, 3);
    else if (gpos[v] == 0) t = 1;
    else if ($urandom_range(0, 2) == 0) t = 3;
    else t = 2;
    if (t == 3) gpos[v] = 0;
    else if (t == 1) gpos[v] = 1;
    return mk(t, $urandom_range(0, 255));
  endfunction

  initial begin
    logic [DW-1:0] hbt [3];
    rst_n = 1'b0; wr_en = 1'b0; vc_sel = '0; data = '0;
    alloc_gnt = '0; chan_rdy = '0;
    model_reset();
    #2;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // H,B,T on VC2, granted once the request is up.
    hbt[0] = mk(1, 8'h21); hbt[1] = mk(2, 8'h22); hbt[2] = mk(3, 8'h23);
    seen.delete();
    cycle(1'b1, 2, hbt[0], 4'h0, 4'hF);
    cycle(1'b1, 2, hbt[1], 4'h0, 4'hF);
    cycle(1'b1, 2, hbt[2], 4'h0, 4'hF);
    cycle(1'b0, 0, '0, 4'b0100, 4'hF);
    idle(6, 4'h0);
    check("hbt_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      check("hbt_flit", (i < seen.size()) ? seen[i] : '1, hbt[i]);

    // Two packets interleaving on VC0 and VC1.
    cycle(1'b1, 0, mk(1, 8'h01), 4'b0011, 4'hF);
    cycle(1'b1, 1, mk(1, 8'h11), 4'b0011, 4'hF);
    cycle(1'b1, 0, mk(2, 8'h02), 4'b0011, 4'hF);
    cycle(1'b1, 1, mk(2, 8'h12), 4'b0011, 4'hF);
    cycle(1'b1, 0, mk(2, 8'h03), 4'b0011, 4'hF);
    cycle(1'b1, 1, mk(2, 8'h13), 4'b0011, 4'hF);
    cycle(1'b1, 0, mk(3, 8'h04), 4'b0011, 4'hF);
    cycle(1'b1, 1, mk(3, 8'h14), 4'b0011, 4'hF);
    idle(8, 4'h0);

    // Overfill VC1: fifth write dropped with an error pulse; then drain.
    cycle(1'b1, 1, mk(1, 8'h31), 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, mk(2, 8'h32 + i), 4'h0, 4'hF);
    idle(2, 4'h0);
    idle(1, 4'b0010);
    idle(5, 4'h0);
    cycle(1'b1, 1, mk(3, 8'h3F), 4'h0, 4'hF);
    idle(3, 4'h0);

    // Stray BODY into idle VC3.
    cycle(1'b1, 3, mk(2, 8'h77), 4'h0, 4'hF);
    idle(3, 4'h0);

    // VC0 stalled by chan_rdy, then reset in the middle of the packet.
    cycle(1'b1, 0, mk(1, 8'h51), 4'h0, 4'hF);
    cycle(1'b1, 0, mk(2, 8'h52), 4'h0, 4'hF);
    cycle(1'b1, 0, mk(2, 8'h53), 4'b0001, 4'hF);
    cycle(1'b1, 0, mk(2, 8'h54), 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, '0, 4'h0, 4'b1110);
    cycle(1'b0, 0, '0, 4'h0, 4'hF);
    apply_reset();
    idle(3, 4'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int s;
      bit w;
      logic [VCN-1:0] g, c;
      if (n == 1500) apply_reset();
      s = $urandom_range(0, VCN - 1);
      w = ($urandom_range(0, 3) != 0);
      g = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      cycle(w, s, w ? gen_flit(s) : '0, g, c);
    end
    idle(2, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
